mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store initiator driving the data port (port B) of the dual-port RAM wrapper on behalf of the execute/mem stage.
//  Accepts one byte/half/word request, generates byte-lane write enables and aligned store data, and sequences the read-valid handshake.
//  Extracts and sign/zero-extends load data and returns a single-cycle response to the pipeline.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in WAIT_RD for ram_read_valid before an error response (>=4)
//  ADDR_W          32  request/RAM address width
// PORTS
//  clk             in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  req_valid       in   1   request present; held until req_ready
//  req_ready       out  1   unit idle and RAM ready; req accepted when req_valid&&req_ready
//  req_op          in   2   MEM_DISABLE/MEM_READ_SEXT/MEM_READ_ZEXT/MEM_WRITE
//  req_size        in   2   00 byte, 01 half, 10 word (11 illegal -> treated as word)
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, right-justified
//  resp_valid      out  1   one-cycle completion pulse (loads and stores)
//  resp_data       out  32  extended load data; 0 for stores/errors
//  resp_err        out  1   timeout (or misalignment, see CONFIGURATION); qualifies resp_valid
//  ram_en          out  1   port-B enable (enB)
//  ram_we          out  4   port-B byte write enables (web); 0000 on reads
//  ram_addr        out  32  port-B byte address (RAM uses [16:2])
//  ram_wdata       out  32  lane-aligned store data (dinB)
//  ram_rdata       in   32  port-B read data (doutB)
//  ram_read_valid  in   1   readValidB
//  ram_not_ready   in   1   NOTready; blocks acceptance while high
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=0 during reset cycle, then follows rule below; resp_valid=0, resp_err=0, resp_data=0; ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0; timer=0.
//  - All RAM-side and response outputs are registered. req_ready = (state==IDLE) && !ram_not_ready (combinational).
//  - FSM: IDLE -> ISSUE on accept of op!=MEM_DISABLE; MEM_DISABLE accepted, no RAM access, resp_valid pulse next cycle, resp_data=0.
//  - ISSUE (1 cycle): ram_en=1, ram_addr={addr[31:2],2'b00}; write: ram_we=lane mask, ram_wdata=replicated data; read: ram_we=0.
//    write -> DONE; read -> WAIT_RD. ram_en/ram_we return to 0 after exactly one cycle (no enB held high: RAM valid follows enB).
//  - WAIT_RD: timer increments each cycle; on ram_read_valid capture ram_rdata -> DONE; on timer==TIMEOUT_CYCLES-1 -> DONE with err.
//  - DONE (1 cycle): resp_valid=1 with resp_data/resp_err; -> IDLE.
//  - Latency (accept edge = N): store resp_valid high in cycle N+2; load resp_valid high in cycle N+4 (RAM valid visible N+2..N+3).
//  - Lane mask: byte 4'b0001<<addr[1:0]; half addr[1]?1100:0011; word 1111. Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  - Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; SEXT replicates msb, ZEXT zero-fills; word passed through.
//  - A ram_read_valid arriving outside WAIT_RD is ignored. Requests not accepted in ISSUE/WAIT_RD/DONE.
//  - Reset mid-operation: abandon transaction, outputs to reset values the next cycle, no response emitted.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 skips ISSUE, -> DONE with resp_err=1, resp_data=0, no RAM access.
//  Not defined: low address bits ignored for alignment (half uses addr[1] only, word uses addr[31:2]); never errors on alignment.
// STRUCTURE
//  - Package mem_pkg: MEM_DISABLE/MEM_READ_SEXT/MEM_READ_ZEXT/MEM_WRITE (2'b00..2'b11), size codes SZ_BYTE/SZ_HALF/SZ_WORD, FSM state enum.
//  - Sub-module mem_lane_align: combinational lane mask, store replication, load extract/extend; reused by the fetch/debug paths.
//  - Top holds FSM, request capture registers, timeout counter.
// TESTING
//  1. SW word 0xDEADBEEF @0x100 -> ISSUE: we=1111, wdata=0xDEADBEEF, addr=0x100; resp_valid cycle N+2, err=0.
//  2. SB 0x000000A5 @0x103 -> we=1000, wdata=0xA5A5A5A5; then LB SEXT @0x103 -> resp_data=0xFFFFFFA5; LBU -> 0x000000A5.
//  3. SH 0x8001 @0x102 -> we=1100; LH SEXT @0x102 -> 0xFFFF8001; LHU -> 0x00008001; load resp_valid at N+4.
//  4. ram_not_ready=1 for 3 cycles with req_valid=1 -> req_ready=0, no ram_en; accepted first cycle not_ready=0.
//  5. Read with ram_read_valid tied 0, TIMEOUT_CYCLES=16 -> resp_valid, resp_err=1, resp_data=0 after 16 WAIT_RD cycles; back to IDLE.
//  6. LW @0x102: with MEM_MISALIGN_TRAP_EN -> err=1, ram_en never 1; without -> reads word @0x100; reset asserted in WAIT_RD -> no resp_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store data-port path.
// Op and size codes, FSM states and the alignment check.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_DISABLE   = 2'b00,
        MEM_READ_SEXT = 2'b01,
        MEM_READ_ZEXT = 2'b10,
        MEM_WRITE     = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Size code 2'b11 is handled as a word everywhere.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic isHalf;
        isHalf = (size == SZ_HALF);
        if (size == SZ_BYTE) return 1'b0;
        if (isHalf)          return lo[0];
        return (lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and RAM port-B signal bundle.
// slave = the access unit, master = pipeline plus RAM side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_read_valid;
    logic              ram_not_ready;

    modport slave (
        input  req_valid, req_op, req_size, req_addr, req_wdata,
        input  ram_rdata, ram_read_valid, ram_not_ready,
        output req_ready, resp_valid, resp_data, resp_err,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_op, req_size, req_addr, req_wdata,
        output ram_rdata, ram_read_valid, ram_not_ready,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_access_unit_lane.sv
// mem_lane_align: byte-lane mask, store replication and load
// extract/extend for a 32-bit word port.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addrLo,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteEn,
    output logic [31:0] wdataAl,
    output logic [31:0] rdataExt
);
    logic [7:0]  b8;
    logic [15:0] h16;

    always_comb begin
        byteEn   = 4'b1111;
        wdataAl  = wdata;
        rdataExt = rdata;
        b8       = rdata[{addrLo, 3'b000} +: 8];
        h16      = rdata[{addrLo[1], 4'b0000} +: 16];
        unique case (1'b1)
            (size == SZ_BYTE): begin
                byteEn   = 4'b0001 << addrLo;
                wdataAl  = {4{wdata[7:0]}};
                rdataExt = {{24{sext & b8[7]}}, b8};
            end
            (size == SZ_HALF): begin
                byteEn   = addrLo[1] ? 4'b1100 : 4'b0011;
                wdataAl  = {2{wdata[15:0]}};
                rdataExt = {{16{sext & h16[15]}}, h16};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for RAM port B: FSM, request capture, timeout.
// Define MEM_MISALIGN_TRAP_EN to error misaligned half/word accesses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input logic               clk,
    input logic               reset,
    mem_access_unit_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state;
    logic [1:0]        opQ;
    logic [1:0]        sizeQ;
    logic [1:0]        loQ;
    logic [TW-1:0]     timer;
    logic              ramEn;
    logic [3:0]        ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [31:0]       ramWdata;
    logic              respValid;
    logic              respErr;
    logic [31:0]       respData;

    logic        accept;
    logic        isIdle;
    logic        trap;
    logic [1:0]  alSize;
    logic [1:0]  alLo;
    logic [3:0]  laneEn;
    logic [31:0] laneWd;
    logic [31:0] laneRd;

    assign isIdle = (state == ST_IDLE);
    assign bus.req_ready = isIdle && !bus.ram_not_ready && !reset;
    assign accept = bus.req_valid && bus.req_ready;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Store lanes come from the live request, load lanes from the capture.
    assign alSize = isIdle ? bus.req_size : sizeQ;
    assign alLo   = isIdle ? bus.req_addr[1:0] : loQ;

    mem_lane_align u_lane (
        .size    (alSize),
        .addrLo  (alLo),
        .sext    (opQ == MEM_READ_SEXT),
        .wdata   (bus.req_wdata),
        .rdata   (bus.ram_rdata),
        .byteEn  (laneEn),
        .wdataAl (laneWd),
        .rdataExt(laneRd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            opQ       <= MEM_DISABLE;
            sizeQ     <= SZ_BYTE;
            loQ       <= '0;
            timer     <= '0;
            ramEn     <= 1'b0;
            ramWe     <= '0;
            ramAddr   <= '0;
            ramWdata  <= '0;
            respValid <= 1'b0;
            respErr   <= 1'b0;
            respData  <= '0;
        end else begin
            ramEn     <= 1'b0;
            ramWe     <= '0;
            respValid <= 1'b0;
            respErr   <= 1'b0;
            respData  <= '0;
            unique case (state)
                ST_IDLE: if (accept) begin
                    opQ   <= bus.req_op;
                    sizeQ <= bus.req_size;
                    loQ   <= bus.req_addr[1:0];
                    if (bus.req_op == MEM_DISABLE) begin
                        state     <= ST_DONE;
                        respValid <= 1'b1;
                    end else if (trap) begin
                        state     <= ST_DONE;
                        respValid <= 1'b1;
                        respErr   <= 1'b1;
                    end else begin
                        state   <= ST_ISSUE;
                        ramEn   <= 1'b1;
                        ramAddr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        if (bus.req_op == MEM_WRITE) begin
                            ramWe    <= laneEn;
                            ramWdata <= laneWd;
                        end else begin
                            ramWdata <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    if (opQ == MEM_WRITE) begin
                        state     <= ST_DONE;
                        respValid <= 1'b1;
                    end else begin
                        state <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    timer <= timer + 1'b1;
                    if (bus.ram_read_valid) begin
                        state     <= ST_DONE;
                        respValid <= 1'b1;
                        respData  <= laneRd;
                    end else if (timer == TLAST) begin
                        state     <= ST_DONE;
                        respValid <= 1'b1;
                        respErr   <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_en     = ramEn;
    assign bus.ram_we     = ramWe;
    assign bus.ram_addr   = ramAddr;
    assign bus.ram_wdata  = ramWdata;
    assign bus.resp_valid = respValid;
    assign bus.resp_err   = respErr;
    assign bus.resp_data  = respData;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a simple port-B RAM model.
// Expected responses are queued at issue and popped on resp_valid.
module tb_mem_access_unit;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic blockValid = 1'b0;
    int nCmp = 0;
    int nErr = 0;
    exp_t sbq[$];

    logic [31:0] mem [0:1023];
    logic        v1 = 1'b0;
    logic [31:0] d1 = '0;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(
        .TIMEOUT_CYCLES(16),
        .ADDR_W        (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Port-B RAM: valid and data appear two edges after the enable is seen.
    always @(posedge clk) begin
        if (bus.ram_en)
            for (int i = 0; i < 4; i++)
                if (bus.ram_we[i])
                    mem[bus.ram_addr[11:2]][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
        v1 <= bus.ram_en && (bus.ram_we == 4'b0000) && !blockValid;
        d1 <= mem[bus.ram_addr[11:2]];
        bus.ram_read_valid <= v1;
        bus.ram_rdata <= d1;
    end

    task automatic xact(
        input  logic [1:0]  op,
        input  logic [1:0]  sz,
        input  logic [31:0] a,
        input  logic [31:0] d,
        output int          lat,
        output logic [31:0] rd,
        output logic        re,
        output logic        en,
        output logic [3:0]  we,
        output logic [31:0] wd,
        output logic [31:0] ad
    );
        int n;
        lat = -1; rd = '0; re = 1'b0; en = 1'b0; we = '0; wd = '0; ad = '0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            lat = -2;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.ram_en) begin
                en = 1'b1;
                we = bus.ram_we;
                wd = bus.ram_wdata;
                ad = bus.ram_addr;
            end
            if (bus.resp_valid) begin
                lat = c;
                rd  = bus.resp_data;
                re  = bus.resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        nCmp++;
        if (bus.req_ready !== 1'b0) begin
            nErr++;
            $display("FAIL reset_ready: got %b want 0", bus.req_ready);
        end
        nCmp++;
        if ({bus.resp_valid, bus.resp_err, bus.ram_en, bus.ram_we} !== 7'd0) begin
            nErr++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {bus.resp_valid, bus.resp_err, bus.ram_en, bus.ram_we});
        end
        nCmp++;
        if ({bus.ram_addr, bus.ram_wdata, bus.resp_data} !== 96'd0) begin
            nErr++;
            $display("FAIL reset_data: got %h want 0",
                     {bus.ram_addr, bus.ram_wdata, bus.resp_data});
        end
        reset = 1'b0;
        @(negedge clk);
        nCmp++;
        if (bus.req_ready !== 1'b1) begin
            nErr++;
            $display("FAIL idle_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_store_word;
        int lat; logic [31:0] rd, wd, ad; logic re, en; logic [3:0] we;
        exp_t e;
        sbq.push_back('{32'h0, 1'b0, 1});
        xact(MEM_WRITE, SZ_WORD, 32'h100, 32'hDEADBEEF, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, re, rd} !== {e.lat, e.err, e.data}) begin
            nErr++;
            $display("FAIL sw_resp: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                     lat, re, rd, e.lat, e.err, e.data);
        end
        nCmp++;
        if ({we, wd, ad} !== {4'b1111, 32'hDEADBEEF, 32'h100}) begin
            nErr++;
            $display("FAIL sw_port: got we=%b wd=%h ad=%h want 1111 deadbeef 00000100",
                     we, wd, ad);
        end
    endtask

    task automatic test_byte_half;
        int lat; logic [31:0] rd, wd, ad; logic re, en; logic [3:0] we;
        exp_t e;
        sbq.push_back('{32'h0, 1'b0, 1});
        xact(MEM_WRITE, SZ_BYTE, 32'h103, 32'h000000A5, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, we, wd} !== {e.lat, 4'b1000, 32'hA5A5A5A5}) begin
            nErr++;
            $display("FAIL sb_port: got lat=%0d we=%b wd=%h want lat=%0d we=1000 wd=a5a5a5a5",
                     lat, we, wd, e.lat);
        end
        sbq.push_back('{32'hFFFFFFA5, 1'b0, 3});
        xact(MEM_READ_SEXT, SZ_BYTE, 32'h103, 32'h0, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, re, rd} !== {e.lat, e.err, e.data}) begin
            nErr++;
            $display("FAIL lb: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                     lat, re, rd, e.lat, e.err, e.data);
        end
        sbq.push_back('{32'h000000A5, 1'b0, 3});
        xact(MEM_READ_ZEXT, SZ_BYTE, 32'h103, 32'h0, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, re, rd} !== {e.lat, e.err, e.data}) begin
            nErr++;
            $display("FAIL lbu: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                     lat, re, rd, e.lat, e.err, e.data);
        end
        sbq.push_back('{32'h0, 1'b0, 1});
        xact(MEM_WRITE, SZ_HALF, 32'h102, 32'h00008001, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, we, wd} !== {e.lat, 4'b1100, 32'h80018001}) begin
            nErr++;
            $display("FAIL sh_port: got lat=%0d we=%b wd=%h want lat=%0d we=1100 wd=80018001",
                     lat, we, wd, e.lat);
        end
        sbq.push_back('{32'hFFFF8001, 1'b0, 3});
        xact(MEM_READ_SEXT, SZ_HALF, 32'h102, 32'h0, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, re, rd, we} !== {e.lat, e.err, e.data, 4'b0000}) begin
            nErr++;
            $display("FAIL lh: got lat=%0d err=%b data=%h we=%b want lat=%0d err=%b data=%h we=0000",
                     lat, re, rd, we, e.lat, e.err, e.data);
        end
        sbq.push_back('{32'h00008001, 1'b0, 3});
        xact(MEM_READ_ZEXT, SZ_HALF, 32'h102, 32'h0, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, re, rd} !== {e.lat, e.err, e.data}) begin
            nErr++;
            $display("FAIL lhu: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                     lat, re, rd, e.lat, e.err, e.data);
        end
    endtask

    task automatic test_not_ready;
        logic seen;
        @(negedge clk);
        bus.ram_not_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = MEM_READ_ZEXT;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'h100;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            nCmp++;
            if ({bus.req_ready, bus.ram_en} !== 2'b00) begin
                nErr++;
                $display("FAIL nr_block%0d: got ready=%b en=%b want 0 0",
                         i, bus.req_ready, bus.ram_en);
            end
            @(negedge clk);
        end
        bus.ram_not_ready = 1'b0;
        #1;
        nCmp++;
        if (bus.req_ready !== 1'b1) begin
            nErr++;
            $display("FAIL nr_release: got %b want 1", bus.req_ready);
        end
        sbq.push_back('{32'h8001BEEF, 1'b0, 3});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        nCmp++;
        if (bus.ram_en !== 1'b1) begin
            nErr++;
            $display("FAIL nr_accept: got en=%b want 1", bus.ram_en);
        end
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (bus.resp_valid) begin
                exp_t e;
                seen = 1'b1;
                e = sbq.pop_front();
                nCmp++;
                if ({c, bus.resp_data} !== {e.lat, e.data}) begin
                    nErr++;
                    $display("FAIL nr_resp: got lat=%0d data=%h want lat=%0d data=%h",
                             c, bus.resp_data, e.lat, e.data);
                end
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            void'(sbq.pop_front());
            nCmp++;
            nErr++;
            $display("FAIL nr_resp: got no response want one");
        end
    endtask

    task automatic test_timeout;
        int lat; logic [31:0] rd, wd, ad; logic re, en; logic [3:0] we;
        exp_t e;
        blockValid = 1'b1;
        sbq.push_back('{32'h0, 1'b1, 17});
        xact(MEM_READ_ZEXT, SZ_WORD, 32'h100, 32'h0, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, re, rd} !== {e.lat, e.err, e.data}) begin
            nErr++;
            $display("FAIL timeout: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                     lat, re, rd, e.lat, e.err, e.data);
        end
        @(negedge clk);
        @(negedge clk);
        nCmp++;
        if (bus.req_ready !== 1'b1) begin
            nErr++;
            $display("FAIL timeout_idle: got %b want 1", bus.req_ready);
        end
        blockValid = 1'b0;
    endtask

    task automatic test_misalign_disable;
        int lat; logic [31:0] rd, wd, ad; logic re, en; logic [3:0] we;
        exp_t e;
`ifdef MEM_MISALIGN_TRAP_EN
        sbq.push_back('{32'h0, 1'b1, 0});
`else
        sbq.push_back('{32'h8001BEEF, 1'b0, 3});
`endif
        xact(MEM_READ_ZEXT, SZ_WORD, 32'h102, 32'h0, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, re, rd} !== {e.lat, e.err, e.data}) begin
            nErr++;
            $display("FAIL lw_mis: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                     lat, re, rd, e.lat, e.err, e.data);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        nCmp++;
        if (en !== 1'b0) begin
            nErr++;
            $display("FAIL lw_mis_en: got %b want 0", en);
        end
`else
        nCmp++;
        if (ad !== 32'h100) begin
            nErr++;
            $display("FAIL lw_mis_addr: got %h want 00000100", ad);
        end
`endif
        sbq.push_back('{32'h0, 1'b0, 0});
        xact(MEM_DISABLE, SZ_WORD, 32'h100, 32'h12345678, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, re, rd, en} !== {e.lat, e.err, e.data, 1'b0}) begin
            nErr++;
            $display("FAIL disable: got lat=%0d err=%b data=%h en=%b want lat=%0d err=%b data=%h en=0",
                     lat, re, rd, en, e.lat, e.err, e.data);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rd, wd, ad; logic re, en; logic [3:0] we;
        exp_t e;
        logic [7:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = 8'($urandom_range(0, 255));
            sbq.push_back('{32'h0, 1'b0, 1});
            xact(MEM_WRITE, SZ_BYTE, 32'h200 + i, {24'h0, v[i]}, lat, rd, re, en, we, wd, ad);
            e = sbq.pop_front();
            nCmp++;
            if ({lat, we} !== {e.lat, 4'b0001 << i}) begin
                nErr++;
                $display("FAIL b2b_sb%0d: got lat=%0d we=%b want lat=%0d lane %0d",
                         i, lat, we, e.lat, i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            sbq.push_back('{{{24{v[i][7]}}, v[i]}, 1'b0, 3});
            xact(MEM_READ_SEXT, SZ_BYTE, 32'h200 + i, 32'h0, lat, rd, re, en, we, wd, ad);
            e = sbq.pop_front();
            nCmp++;
            if ({lat, re, rd} !== {e.lat, e.err, e.data}) begin
                nErr++;
                $display("FAIL b2b_lb%0d: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                         i, lat, re, rd, e.lat, e.err, e.data);
            end
        end
        sbq.push_back('{{v[3], v[2], v[1], v[0]}, 1'b0, 3});
        xact(MEM_READ_ZEXT, SZ_WORD, 32'h200, 32'h0, lat, rd, re, en, we, wd, ad);
        e = sbq.pop_front();
        nCmp++;
        if ({lat, re, rd} !== {e.lat, e.err, e.data}) begin
            nErr++;
            $display("FAIL b2b_lw: got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                     lat, re, rd, e.lat, e.err, e.data);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        blockValid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = MEM_READ_ZEXT;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'h100;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        blockValid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
        nCmp++;
        if (pulses !== 0) begin
            nErr++;
            $display("FAIL reset_mid_resp: got %0d pulses want 0", pulses);
        end
        nCmp++;
        if ({bus.req_ready, bus.ram_en, bus.ram_addr} !== {1'b1, 1'b0, 32'h0}) begin
            nErr++;
            $display("FAIL reset_mid_state: got ready=%b en=%b addr=%h want 1 0 00000000",
                     bus.req_ready, bus.ram_en, bus.ram_addr);
        end
    endtask

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_op        = MEM_DISABLE;
        bus.req_size      = SZ_BYTE;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.ram_not_ready = 1'b0;
        test_reset();
        test_store_word();
        test_byte_half();
        test_not_ready();
        test_timeout();
        test_misalign_disable();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
